// File: rtl/next_pc_pkg.sv
// Shared definitions for the next-PC unit: default sizes and the
// encoding of which source feeds pc_next in a given cycle.
package next_pc_pkg;

  localparam int PC_W_DEF      = 8;
  localparam int RAS_DEPTH_DEF = 4;

  typedef enum logic [2:0] {
    SEL_SEQ  = 3'd0,
    SEL_BR   = 3'd1,
    SEL_JMP  = 3'd2,
    SEL_CALL = 3'd3,
    SEL_RET  = 3'd4,
    SEL_HOLD = 3'd5
  } next_sel_e;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack. A push onto a full stack silently
// overwrites the oldest entry, because the write pointer has wrapped
// around onto it; the count saturates at DEPTH.
module ras_stack #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         replace,
  input  logic [W-1:0] wr_data,
  output logic [W-1:0] top,
  output logic         empty,
  output logic         full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_ptr;
  logic [AW:0]   r_count;
  logic [AW-1:0] w_topIdx;

  assign w_topIdx = r_ptr - AW'(1);
  assign top      = r_mem[w_topIdx];
  assign empty    = (r_count == '0);
  assign full     = (r_count == FULL_CNT);

  // Pointer, count and entry storage; push wins over replace wins over pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_ptr   <= '0;
      r_count <= '0;
    end else if (push) begin
      r_mem[r_ptr] <= wr_data;
      r_ptr        <= r_ptr + AW'(1);
      if (r_count != FULL_CNT) begin
        r_count <= r_count + (AW+1)'(1);
      end
    end else if (replace) begin
      r_mem[w_topIdx] <= wr_data;
    end else if (pop) begin
      r_ptr   <= r_ptr - AW'(1);
      r_count <= r_count - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/next_pc_unit.sv
// Next-PC selection with a return-address stack. pc_next is purely
// combinational from the current request; stack and sticky flags
// update on the following clock edge.
module next_pc_unit
  import next_pc_pkg::*;
#(
  parameter int PC_W      = PC_W_DEF,
  parameter int RAS_DEPTH = RAS_DEPTH_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [PC_W-1:0] pc_cur,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_off,
  input  logic            jump,
  input  logic            call,
  input  logic            ret,
  input  logic [PC_W-1:0] jump_target,
  output logic [PC_W-1:0] pc_next,
  output logic            ras_empty,
  output logic            ras_full,
  output logic            ras_ovf,
  output logic            ras_unf
);

  next_sel_e       w_sel;
  logic            w_push;
  logic            w_pop;
  logic            w_replace;
  logic            w_unfReq;
  logic [PC_W-1:0] w_pcInc;
  logic [PC_W-1:0] w_top;
  logic            r_ovf;
  logic            r_unf;

  assign w_pcInc = pc_cur + PC_W'(1);

  // Request arbitration: pick the pc_next source and the stack operation.
  always_comb begin
    w_sel     = SEL_SEQ;
    w_push    = 1'b0;
    w_pop     = 1'b0;
    w_replace = 1'b0;
    w_unfReq  = 1'b0;
    if (reset) begin
      w_sel = SEL_HOLD;
    end else if (stall) begin
      w_sel = SEL_HOLD;
    end else if (call && ret) begin
      w_sel = SEL_CALL;
      if (ras_empty) begin
        w_push = 1'b1;
      end else begin
        w_replace = 1'b1;
      end
    end else if (ret) begin
      if (ras_empty) begin
        w_sel    = SEL_SEQ;
        w_unfReq = 1'b1;
      end else begin
        w_sel = SEL_RET;
        w_pop = 1'b1;
      end
    end else if (call) begin
      w_sel  = SEL_CALL;
      w_push = 1'b1;
    end else if (jump) begin
      w_sel = SEL_JMP;
    end else if (branch_taken) begin
      w_sel = SEL_BR;
    end
  end

  // pc_next mux; reset forces zero regardless of the selected source.
  always_comb begin
    pc_next = w_pcInc;
    if (reset) begin
      pc_next = '0;
    end else begin
      case (w_sel)
        SEL_SEQ:  pc_next = w_pcInc;
        SEL_BR:   pc_next = w_pcInc + branch_off;
        SEL_JMP:  pc_next = jump_target;
        SEL_CALL: pc_next = jump_target;
        SEL_RET:  pc_next = w_top;
        SEL_HOLD: pc_next = pc_cur;
        default:  pc_next = w_pcInc;
      endcase
    end
  end

  // Sticky overflow/underflow flags, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      if (w_push && ras_full) begin
        r_ovf <= 1'b1;
      end
      if (w_unfReq) begin
        r_unf <= 1'b1;
      end
    end
  end

  assign ras_ovf = r_ovf;
  assign ras_unf = r_unf;

  ras_stack #(
    .W     (PC_W),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk     (clk),
    .reset   (reset),
    .push    (w_push),
    .pop     (w_pop),
    .replace (w_replace),
    .wr_data (w_pcInc),
    .top     (w_top),
    .empty   (ras_empty),
    .full    (ras_full)
  );

endmodule

// File: tb/tb_next_pc_unit.sv
// Directed and randomized checks of next_pc_unit against a queue-based
// model of the return-address stack.
module tb_next_pc_unit;

  localparam int PC_W  = 8;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [PC_W-1:0] pc_cur = '0;
  logic            stall = 1'b0;
  logic            branch_taken = 1'b0;
  logic [PC_W-1:0] branch_off = '0;
  logic            jump = 1'b0;
  logic            call = 1'b0;
  logic            ret = 1'b0;
  logic [PC_W-1:0] jump_target = '0;
  logic [PC_W-1:0] pc_next;
  logic            ras_empty;
  logic            ras_full;
  logic            ras_ovf;
  logic            ras_unf;

  int checks = 0;
  int failures = 0;

  logic [PC_W-1:0] mStack[$];
  bit              mOvf = 1'b0;
  bit              mUnf = 1'b0;
  logic [PC_W-1:0] lastPcNext;

  always #5 clk = ~clk;

  next_pc_unit #(.PC_W(PC_W), .RAS_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .pc_cur       (pc_cur),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_off   (branch_off),
    .jump         (jump),
    .call         (call),
    .ret          (ret),
    .jump_target  (jump_target),
    .pc_next      (pc_next),
    .ras_empty    (ras_empty),
    .ras_full     (ras_full),
    .ras_ovf      (ras_ovf),
    .ras_unf      (ras_unf)
  );

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected pc_next from the request priority rules.
  function automatic logic [PC_W-1:0] modelNext();
    if (reset) return '0;
    if (stall) return pc_cur;
    if (call) return jump_target;
    if (ret) return (mStack.size() > 0) ? mStack[$] : PC_W'(pc_cur + 1);
    if (jump) return jump_target;
    if (branch_taken) return PC_W'(pc_cur + 1 + branch_off);
    return PC_W'(pc_cur + 1);
  endfunction

  // Stack/flag effect of the current request at the clock edge.
  task automatic modelUpdate();
    logic [PC_W-1:0] ra;
    ra = PC_W'(pc_cur + 1);
    if (reset) begin
      mStack.delete();
      mOvf = 1'b0;
      mUnf = 1'b0;
    end else if (stall) begin
    end else if (call && ret && mStack.size() > 0) begin
      mStack[mStack.size()-1] = ra;
    end else if (call) begin
      mStack.push_back(ra);
      if (mStack.size() > DEPTH) begin
        void'(mStack.pop_front());
        mOvf = 1'b1;
      end
    end else if (ret) begin
      if (mStack.size() > 0) void'(mStack.pop_back());
      else mUnf = 1'b1;
    end
  endtask

  task automatic checkOutput(input string tag);
    checkVal({tag, ".empty"}, 32'(ras_empty), 32'(mStack.size() == 0));
    checkVal({tag, ".full"},  32'(ras_full),  32'(mStack.size() == DEPTH));
    checkVal({tag, ".ovf"},   32'(ras_ovf),   32'(mOvf));
    checkVal({tag, ".unf"},   32'(ras_unf),   32'(mUnf));
  endtask

  // One cycle: drive request, check combinational pc_next, clock, check state.
  task automatic applyStimulus(input string tag, input logic [PC_W-1:0] pc,
                               input logic st, input logic cl, input logic rt,
                               input logic jp, input logic [PC_W-1:0] tgt,
                               input logic br, input logic [PC_W-1:0] off);
    pc_cur = pc; stall = st; call = cl; ret = rt; jump = jp;
    jump_target = tgt; branch_taken = br; branch_off = off;
    #1;
    lastPcNext = pc_next;
    checkVal({tag, ".pc_next"}, 32'(pc_next), 32'(modelNext()));
    @(posedge clk);
    modelUpdate();
    #1;
    checkOutput(tag);
  endtask

  task automatic resetDut(input string tag, input logic withCall);
    reset = 1'b1; call = withCall; ret = 1'b0; stall = 1'b0;
    pc_cur = 8'h37; jump_target = 8'h99;
    #1;
    checkVal({tag, ".pc_next"}, 32'(pc_next), 32'h0);
    @(posedge clk);
    modelUpdate();
    #1;
    checkOutput(tag);
    reset = 1'b0; call = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    resetDut("reset0", 1'b0);
    checkVal("reset0.emptyConst", 32'(ras_empty), 32'h1);

    applyStimulus("seqWrap", 8'hFF, 0, 0, 0, 0, 8'h00, 0, 8'h00);
    checkVal("seqWrap.const", 32'(lastPcNext), 32'h00);
    applyStimulus("brNeg", 8'h10, 0, 0, 0, 0, 8'h00, 1, 8'hFC);
    checkVal("brNeg.const", 32'(lastPcNext), 32'h0D);
    applyStimulus("brPos", 8'h10, 0, 0, 0, 0, 8'h00, 1, 8'h05);
    checkVal("brPos.const", 32'(lastPcNext), 32'h16);
    applyStimulus("jump", 8'h22, 0, 0, 0, 1, 8'hA5, 1, 8'h05);

    applyStimulus("call1", 8'h20, 0, 1, 0, 0, 8'h40, 0, 8'h00);
    applyStimulus("call2", 8'h40, 0, 1, 0, 0, 8'h60, 0, 8'h00);
    applyStimulus("ret1", 8'h60, 0, 0, 1, 0, 8'h00, 0, 8'h00);
    checkVal("ret1.const", 32'(lastPcNext), 32'h41);
    applyStimulus("ret2", 8'h41, 0, 0, 1, 0, 8'h00, 0, 8'h00);
    checkVal("ret2.const", 32'(lastPcNext), 32'h21);
    checkVal("nest.emptyConst", 32'(ras_empty), 32'h1);

    for (int i = 1; i <= 5; i++) begin
      applyStimulus("ovfCall", PC_W'(i), 0, 1, 0, 0, 8'hC0, 0, 8'h00);
    end
    checkVal("ovf.const", 32'(ras_ovf), 32'h1);
    applyStimulus("ovfRet1", 8'hC0, 0, 0, 1, 0, 8'h00, 0, 8'h00);
    checkVal("ovfRet1.const", 32'(lastPcNext), 32'h06);
    applyStimulus("ovfRet2", 8'hC1, 0, 0, 1, 0, 8'h00, 0, 8'h00);
    checkVal("ovfRet2.const", 32'(lastPcNext), 32'h05);
    applyStimulus("ovfRet3", 8'hC2, 0, 0, 1, 0, 8'h00, 0, 8'h00);
    checkVal("ovfRet3.const", 32'(lastPcNext), 32'h04);
    applyStimulus("ovfRet4", 8'hC3, 0, 0, 1, 0, 8'h00, 0, 8'h00);
    checkVal("ovfRet4.const", 32'(lastPcNext), 32'h03);
    applyStimulus("unfRet", 8'hC4, 0, 0, 1, 0, 8'h00, 0, 8'h00);
    checkVal("unfRet.const", 32'(lastPcNext), 32'hC5);
    checkVal("unf.const", 32'(ras_unf), 32'h1);
    applyStimulus("callRetEmpty", 8'h70, 0, 1, 1, 0, 8'h75, 0, 8'h00);

    resetDut("reset1", 1'b0);
    applyStimulus("prCall", 8'h30, 0, 1, 0, 0, 8'h50, 0, 8'h00);
    applyStimulus("prStall", 8'h50, 1, 1, 1, 1, 8'h80, 1, 8'h03);
    checkVal("prStall.const", 32'(lastPcNext), 32'h50);
    applyStimulus("prCallRet", 8'h50, 0, 1, 1, 0, 8'h80, 0, 8'h00);
    checkVal("prCallRet.const", 32'(lastPcNext), 32'h80);
    applyStimulus("prRet", 8'h90, 0, 0, 1, 0, 8'h00, 0, 8'h00);
    checkVal("prRet.const", 32'(lastPcNext), 32'h51);

    applyStimulus("midCall1", 8'h11, 0, 1, 0, 0, 8'h60, 0, 8'h00);
    applyStimulus("midCall2", 8'h61, 0, 1, 0, 0, 8'h70, 0, 8'h00);
    resetDut("midReset", 1'b1);
    checkVal("midReset.emptyConst", 32'(ras_empty), 32'h1);
    checkVal("midReset.ovfConst", 32'(ras_ovf), 32'h0);
    checkVal("midReset.unfConst", 32'(ras_unf), 32'h0);

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 39) == 0) begin
        resetDut("rndReset", 1'($urandom_range(0, 1)));
      end else begin
        applyStimulus("rnd", PC_W'($urandom),
                      1'($urandom_range(0, 9) == 0),
                      1'($urandom_range(0, 2) == 0),
                      1'($urandom_range(0, 2) == 0),
                      1'($urandom_range(0, 1)),
                      PC_W'($urandom),
                      1'($urandom_range(0, 1)),
                      PC_W'($urandom));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/next_pc_unit.md
NEXT_PC_UNIT -- requirements
Module: next_pc_unit

Interface
REQ-001 SHALL have parameter PC_W, default 8, program-counter width in bits.
REQ-002 SHALL have parameter RAS_DEPTH, default 4, number of return-address-stack entries (power of two, at least 2).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port pc_cur, input, PC_W bits: current program counter value.
REQ-006 SHALL have port stall, input, 1 bit: hold the current PC; no stack update.
REQ-007 SHALL have port branch_taken, input, 1 bit: conditional branch resolved as taken.
REQ-008 SHALL have port branch_off, input, PC_W bits: signed two's-complement branch offset.
REQ-009 SHALL have port jump, input, 1 bit: unconditional jump to jump_target.
REQ-010 SHALL have port call, input, 1 bit: jump to jump_target and push the return address.
REQ-011 SHALL have port ret, input, 1 bit: pop the return address and go to it.
REQ-012 SHALL have port jump_target, input, PC_W bits: absolute target for jump and call.
REQ-013 SHALL have port pc_next, output, PC_W bits: next program counter value.
REQ-014 SHALL have port ras_empty, output, 1 bit: stack holds 0 entries.
REQ-015 SHALL have port ras_full, output, 1 bit: stack holds RAS_DEPTH entries.
REQ-016 SHALL have port ras_ovf, output, 1 bit: sticky flag, a push was made while the stack was full.
REQ-017 SHALL have port ras_unf, output, 1 bit: sticky flag, a pop was attempted while the stack was empty.

Function
REQ-018 SHALL compute pc_next combinationally in the same cycle (zero latency); stack, count and flags SHALL update at the next clk edge.
REQ-019 SHALL resolve requests in priority order: reset > stall > call+ret together > ret > call > jump > branch_taken > sequential.
REQ-020 SHALL drive sequential pc_next = pc_cur+1, modulo 2^PC_W (8'hFF wraps to 8'h00).
REQ-021 SHALL drive branch pc_next = pc_cur+1+branch_off, sign-extended, modulo 2^PC_W.
REQ-022 SHALL drive jump pc_next = jump_target, with no stack change.
REQ-023 SHALL, on call, drive pc_next = jump_target and push pc_cur+1 (wrapped).
REQ-024 SHALL, on a call with the stack full, overwrite the oldest entry (circular), keep count = RAS_DEPTH, and set ras_ovf.
REQ-025 SHALL, on ret with the stack not empty, drive pc_next = top of stack and pop.
REQ-026 SHALL, on ret with the stack empty, drive pc_next = pc_cur+1, leave the stack unchanged, and set ras_unf.
REQ-027 SHALL, on call and ret together with the stack not empty, drive pc_next = jump_target, replace the top with pc_cur+1, and leave count unchanged.
REQ-028 SHALL treat call and ret together with the stack empty as call only, without setting ras_unf.
REQ-029 SHALL, on stall, drive pc_next = pc_cur and ignore all other requests, with no state change.
REQ-030 SHALL keep ras_ovf and ras_unf set until reset.

Reset
REQ-031 SHALL, while reset is high, force pc_next = 0.
REQ-032 SHALL, at a clk edge with reset high, clear the pointer and count (ras_empty=1, ras_full=0), clear ras_ovf and ras_unf, and zero all entries.
REQ-033 SHALL discard any push or pop requested in the same cycle as reset.

Structure
REQ-034 SHALL place PC_W, RAS_DEPTH defaults and the next-PC select encoding (SEQ, BR, JMP, CALL, RET, HOLD) in the shared package next_pc_pkg.
REQ-035 SHALL implement the stack as sub-module ras_stack (push, pop, replace, top, empty, full).

Verification
REQ-036 SHALL verify sequential wrap: pc_cur=8'hFF with no request -> pc_next=8'h00.
REQ-037 SHALL verify branch: pc_cur=8'h10 with branch_taken and branch_off=8'hFC -> pc_next=8'h0D; with branch_off=8'h05 -> pc_next=8'h16.
REQ-038 SHALL verify nested calls: calls from pc_cur=8'h20, then 8'h40, then rets -> pc_next=8'h41, then 8'h21, then ras_empty=1.
REQ-039 SHALL verify overflow: 5 calls from 8'h01..8'h05 -> ras_ovf=1; 4 rets return 8'h06, 8'h05, 8'h04, 8'h03; a 5th ret -> pc_next=pc_cur+1 and ras_unf=1.
REQ-040 SHALL verify priority: stall with call and ret asserted -> pc_next=pc_cur and no state change; call+ret with top=8'h31, pc_cur=8'h50, jump_target=8'h80 -> pc_next=8'h80 and new top=8'h51.
REQ-041 SHALL verify reset mid-operation: reset with call asserted and 2 entries held -> pc_next=0 while reset is high; after release ras_empty=1, ras_ovf=0 and ras_unf=0.
